// File: rtl/axis_lane_packer_if.sv
// Stream bundle around axis_lane_packer: the sparse input channel (s_*) and
// the packed output channel (m_*) with their handshakes.
//   slave  : packer's view (consumes s_*, m_ready; drives s_ready, m_*)
//   master : environment's view (producer upstream + consumer downstream)
interface axis_lane_packer_if #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
);
  logic [LANES*LANE_W-1:0] s_data;
  logic [LANES-1:0]        s_keep;
  logic                    s_valid;
  logic                    s_last;
  logic                    s_ready;
  logic [LANES*LANE_W-1:0] m_data;
  logic [LANES-1:0]        m_keep;
  logic                    m_valid;
  logic                    m_last;
  logic                    m_seg;
  logic                    m_ready;

  modport slave (
    input  s_data, s_keep, s_valid, s_last, m_ready,
    output s_ready, m_data, m_keep, m_valid, m_last, m_seg
  );

  modport master (
    output s_data, s_keep, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_keep, m_valid, m_last, m_seg
  );
endinterface

// File: rtl/axis_lane_packer.sv
// axis_lane_packer: repacks sparse input beats (contiguous low lanes valid)
// into dense output beats via a circular lane buffer. Lanes of different
// packets are never merged; packets can optionally be cut into segments of
// seg_len lanes, each segment end flagged with m_last (+ m_seg).
// Ports:
//   clk      : clock, rising edge
//   arst     : synchronous active-high reset
//   bus      : s_* input stream, m_* packed output stream (slave modport)
//   seg_len  : lanes per segment, 0 = no segmentation (latched per packet)
//   keep_err : sticky, a non-contiguous s_keep was accepted
module axis_lane_packer #(
  parameter int LANE_W      = 4,
  parameter int LANES       = 4,
  parameter int DEPTH_LANES = 64,
  parameter int SEG_W       = 12
) (
  input  logic                 clk,
  input  logic                 arst,
  axis_lane_packer_if.slave    bus,
  input  logic [SEG_W-1:0]     seg_len,
  output logic                 keep_err
);
  localparam int PW = $clog2(DEPTH_LANES);
  localparam int FW = PW + 1;

  logic [LANE_W-1:0]       r_buf [DEPTH_LANES];
  logic [DEPTH_LANES-1:0]  r_end;        // lane closes its packet
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [FW-1:0]           r_fill;
  logic                    r_in_pkt;     // current input packet holds >= 1 lane
  logic [SEG_W-1:0]        r_seg_cnt, r_seg_len;
  logic                    r_pkt_first;  // next output beat starts a packet
  logic [LANES*LANE_W-1:0] r_m_data;
  logic [LANES-1:0]        r_m_keep;
  logic                    r_m_valid, r_m_last, r_m_seg, r_keep_err;

  // ---------------- input side ----------------
  logic [FW-1:0] w_wcnt, w_wr_cnt;
  logic          w_keep_bad, w_run, w_s_ready, w_acc;

  // Lane count = run of ones from lane 0; anything set above the run is bad.
  always_comb begin
    w_wcnt     = '0;
    w_keep_bad = 1'b0;
    w_run      = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (bus.s_keep[i]) begin
        if (w_run) w_wcnt = w_wcnt + FW'(1);
        else       w_keep_bad = 1'b1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // Based on registered fill only, so no path from m_ready to s_ready.
  assign w_s_ready = (FW'(DEPTH_LANES) - r_fill) >= FW'(LANES);
  assign w_acc     = bus.s_valid & w_s_ready;
  assign w_wr_cnt  = w_acc ? w_wcnt : '0;

  // ---------------- output side ----------------
  logic [SEG_W-1:0]        w_seg_len_eff, w_seg_rem;
  logic [FW-1:0]           w_n, w_avail, w_end_k, w_len, w_rd_cnt;
  logic                    w_found, w_can_load, w_load, w_seg_end;
  logic [LANES*LANE_W-1:0] w_beat_data;
  logic [LANES-1:0]        w_beat_keep;

  // seg_len is sampled on the first beat of a packet and held after that.
  assign w_seg_len_eff = r_pkt_first ? seg_len : r_seg_len;
  assign w_seg_rem     = w_seg_len_eff - r_seg_cnt;

  always_comb begin
    w_n = FW'(LANES);
    if (w_seg_len_eff != '0 && w_seg_rem < SEG_W'(LANES)) w_n = FW'(w_seg_rem);
    w_avail = (r_fill < w_n) ? r_fill : w_n;
    // First end marker among the lanes this beat could take.
    w_found = 1'b0;
    w_end_k = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!w_found && FW'(k) < w_avail && r_end[r_rd_ptr + PW'(k)]) begin
        w_found = 1'b1;
        w_end_k = FW'(k);
      end
    end
    w_len      = w_found ? w_end_k + FW'(1) : w_n;
    w_can_load = (r_fill >= w_n) || w_found;
    w_load     = w_can_load && (!r_m_valid || bus.m_ready);
    w_seg_end  = (w_seg_len_eff != '0) && (r_seg_cnt + SEG_W'(w_len) == w_seg_len_eff);
    w_rd_cnt   = w_load ? w_len : '0;
    w_beat_data = '0;
    w_beat_keep = '0;
    for (int k = 0; k < LANES; k++) begin
      if (FW'(k) < w_len) begin
        w_beat_data[k*LANE_W +: LANE_W] = r_buf[r_rd_ptr + PW'(k)];
        w_beat_keep[k] = 1'b1;
      end
    end
  end

  // Lane payload needs no reset: pointers and fill define what is live.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int i = 0; i < LANES; i++)
        if (FW'(i) < w_wcnt) r_buf[r_wr_ptr + PW'(i)] <= bus.s_data[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_end       <= '0;
      r_in_pkt    <= 1'b0;
      r_seg_cnt   <= '0;
      r_seg_len   <= '0;
      r_pkt_first <= 1'b1;
      r_m_data    <= '0;
      r_m_keep    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_seg     <= 1'b0;
      r_keep_err  <= 1'b0;
    end else begin
      if (w_acc) begin
        // Every written lane rewrites its marker, so stale marks never survive.
        for (int i = 0; i < LANES; i++)
          if (FW'(i) < w_wcnt)
            r_end[r_wr_ptr + PW'(i)] <= bus.s_last && (FW'(i) == w_wcnt - FW'(1));
        // Empty last beat closes the packet on its previous lane, if any.
        if (w_wcnt == '0 && bus.s_last && r_in_pkt) r_end[r_wr_ptr - PW'(1)] <= 1'b1;
        r_wr_ptr <= r_wr_ptr + PW'(w_wcnt);
        if (bus.s_last)          r_in_pkt <= 1'b0;
        else if (w_wcnt != '0)   r_in_pkt <= 1'b1;
        if (w_keep_bad)          r_keep_err <= 1'b1;
      end
      r_fill <= r_fill + w_wr_cnt - w_rd_cnt;

      if (!r_m_valid || bus.m_ready) begin
        r_m_valid <= w_can_load;
        if (w_can_load) begin
          r_m_data    <= w_beat_data;
          r_m_keep    <= w_beat_keep;
          r_m_last    <= w_found || w_seg_end;
          r_m_seg     <= w_seg_end && !w_found;
          r_rd_ptr    <= r_rd_ptr + PW'(w_len);
          r_seg_cnt   <= (w_found || w_seg_end) ? '0 : r_seg_cnt + SEG_W'(w_len);
          if (r_pkt_first) r_seg_len <= seg_len;
          r_pkt_first <= w_found;
        end else begin
          r_m_data <= '0;
          r_m_keep <= '0;
          r_m_last <= 1'b0;
          r_m_seg  <= 1'b0;
        end
      end
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_data  = r_m_data;
  assign bus.m_keep  = r_m_keep;
  assign bus.m_valid = r_m_valid;
  assign bus.m_last  = r_m_last;
  assign bus.m_seg   = r_m_seg;
  assign keep_err    = r_keep_err;
endmodule

// File: tb/tb_axis_lane_packer.sv
// Scoreboard bench for axis_lane_packer: packets are chunked into expected
// output beats when issued; a negedge monitor pops and compares every
// transferred output beat.
module tb_axis_lane_packer;
  localparam int LANE_W = 4, LANES = 4, DEPTH = 16, SEG_W = 12;
  localparam int DW = LANES * LANE_W;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [LANES-1:0] keep;
    logic             last;
    logic             seg;
  } beat_t;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic [SEG_W-1:0] seg_len = '0;
  logic             keep_err;

  axis_lane_packer_if #(.LANE_W(LANE_W), .LANES(LANES)) bus();

  axis_lane_packer #(.LANE_W(LANE_W), .LANES(LANES), .DEPTH_LANES(DEPTH), .SEG_W(SEG_W)) dut (
    .clk(clk), .arst(arst), .bus(bus), .seg_len(seg_len), .keep_err(keep_err)
  );

  always #5 clk = ~clk;

  int               checks = 0, failures = 0;
  int               mr_mode = 1;          // 0: hold off, 1: always ready, 2: random
  beat_t            exp_q[$];
  beat_t            mon_e;
  logic [LANE_W-1:0] pkt_lanes[$];
  int               pkt_cnts[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready driver (sole writer of m_ready).
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (mr_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: a beat transfers at the next posedge when valid & ready now.
  always @(negedge clk) begin
    if (!arst && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_beat: got data %h keep %b with none expected", bus.m_data, bus.m_keep);
      end else begin
        mon_e = exp_q.pop_front();
        check("m_data", 32'(bus.m_data), 32'(mon_e.data));
        check("m_keep", 32'(bus.m_keep), 32'(mon_e.keep));
        check("m_last", 32'(bus.m_last), 32'(mon_e.last));
        check("m_seg",  32'(bus.m_seg),  32'(mon_e.seg));
      end
    end
  end

  // Reference: cut the packet into segments of sl lanes, each segment into
  // beats of at most LANES lanes.
  function automatic void model_pkt(input int sl);
    int L, pos, segpos, n;
    beat_t b;
    L = pkt_lanes.size(); pos = 0; segpos = 0;
    while (pos < L) begin
      n = LANES;
      if (sl != 0 && sl - segpos < n) n = sl - segpos;
      if (L - pos < n) n = L - pos;
      b = '0;
      for (int k = 0; k < n; k++) begin
        b.data[k*LANE_W +: LANE_W] = pkt_lanes[pos+k];
        b.keep[k] = 1'b1;
      end
      pos += n; segpos += n;
      b.last = (pos == L) || (sl != 0 && segpos == sl);
      b.seg  = (sl != 0 && segpos == sl) && (pos != L);
      if (b.last) segpos = 0;
      exp_q.push_back(b);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance or timeout.
  task automatic send_beat(input logic [DW-1:0] d, input logic [LANES-1:0] k,
                           input logic l, input int maxc, output bit ok);
    ok = 1'b0;
    bus.s_data = d; bus.s_keep = k; bus.s_last = l; bus.s_valid = 1'b1;
    for (int c = 0; c < maxc && !ok; c++) begin
      @(negedge clk);
      if (bus.s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_pkt();
    int idx, cnt;
    logic [DW-1:0] d;
    logic [LANES-1:0] kp;
    bit ok;
    model_pkt(int'(seg_len));
    idx = 0;
    for (int b = 0; b < pkt_cnts.size(); b++) begin
      cnt = pkt_cnts[b];
      d = DW'($urandom);   // junk in unused lanes must be ignored
      kp = '0;
      for (int k = 0; k < cnt; k++) begin
        d[k*LANE_W +: LANE_W] = pkt_lanes[idx+k];
        kp[k] = 1'b1;
      end
      idx += cnt;
      send_beat(d, kp, (b == pkt_cnts.size() - 1), 300, ok);
      if (!ok) begin
        checks++; failures++;
        $display("FAIL send_timeout: beat %0d not accepted, required acceptance", b);
      end
    end
  endtask

  task automatic gen_pkt();
    int L, rem, c;
    pkt_lanes.delete(); pkt_cnts.delete();
    L = $urandom_range(1, 14);
    for (int i = 0; i < L; i++) pkt_lanes.push_back(LANE_W'($urandom));
    rem = L;
    while (rem > 0) begin
      if ($urandom_range(0, 7) == 0) pkt_cnts.push_back(0);
      c = $urandom_range(1, (rem < LANES) ? rem : LANES);
      pkt_cnts.push_back(c);
      rem -= c;
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit ok;
    logic [DW-1:0] d;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_keep = '0; bus.s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    check("rst_m_valid",  32'(bus.m_valid), 32'd0);
    check("rst_s_ready",  32'(bus.s_ready), 32'd1);
    check("rst_keep_err", 32'(keep_err),    32'd0);
    check("rst_m_data",   32'(bus.m_data),  32'd0);
    check("rst_m_keep",   32'(bus.m_keep),  32'd0);
    check("rst_m_last",   32'(bus.m_last),  32'd0);
    @(posedge clk); #1;

    // Packing: 2+3+4 lanes -> 3210, 7654, 0008(last)
    pkt_lanes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    pkt_cnts  = '{2, 3, 4};
    send_pkt(); wait_drain();

    // Segmentation: 16 lanes, seg_len 6
    seg_len = 12'd6;
    pkt_lanes.delete();
    for (int k = 0; k < 16; k++) pkt_lanes.push_back(LANE_W'(k));
    pkt_cnts = '{4, 4, 4, 4};
    send_pkt(); wait_drain();
    seg_len = '0;

    // Packet isolation: both packets buffered together before draining
    mr_mode = 0; @(posedge clk); @(posedge clk); #1;
    pkt_lanes = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE}; pkt_cnts = '{4, 1}; send_pkt();
    pkt_lanes = '{4'h1, 4'h2, 4'h3};             pkt_cnts = '{3};    send_pkt();
    mr_mode = 1; wait_drain();

    // Backpressure: exactly 5 full beats fit, then s_ready drops
    mr_mode = 0; @(posedge clk); @(posedge clk); #1;
    pkt_lanes.delete();
    for (int k = 0; k < 20; k++) pkt_lanes.push_back(LANE_W'($urandom));
    model_pkt(0);
    acc = 0;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < LANES; k++) d[k*LANE_W +: LANE_W] = pkt_lanes[b*LANES+k];
      send_beat(d, 4'hF, (b == 4), 3, ok);
      acc += int'(ok);
    end
    pkt_lanes = '{4'h9}; model_pkt(0);
    send_beat(16'h0009, 4'b0001, 1'b1, 8, ok);
    acc += int'(ok);
    check("bp_accepted", 32'(acc), 32'd5);
    @(negedge clk);
    check("bp_s_ready", 32'(bus.s_ready), 32'd0);
    @(posedge clk); #1;
    mr_mode = 1;
    send_beat(16'h0009, 4'b0001, 1'b1, 100, ok);
    check("bp_late_accept", 32'(ok), 32'd1);
    wait_drain();

    // Keep error: 0101 stores only lane 0
    exp_q.push_back('{data: 16'h0005, keep: 4'b0001, last: 1'b1, seg: 1'b0});
    send_beat(16'h0A05, 4'b0101, 1'b1, 50, ok);
    @(negedge clk);
    check("keep_err_set", 32'(keep_err), 32'd1);
    @(posedge clk); #1;
    gen_pkt(); send_pkt(); wait_drain();
    check("keep_err_sticky", 32'(keep_err), 32'd1);

    // Randomised traffic across segmentation settings
    foreach (pkt_cnts[i]) ; // no-op keeps queue untouched
    for (int s = 0; s < 4; s++) begin
      seg_len = (s == 0) ? 12'd0 : SEG_W'($urandom_range(1, 10));
      mr_mode = 2;
      for (int p = 0; p < 25; p++) begin gen_pkt(); send_pkt(); end
      mr_mode = 1;
      wait_drain();
    end
    seg_len = '0;

    // Reset in the middle of a packet
    mr_mode = 0; @(posedge clk); @(posedge clk); #1;
    send_beat(16'h1111, 4'hF, 1'b0, 5, ok);
    send_beat(16'h2222, 4'hF, 1'b0, 5, ok);
    arst = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    @(negedge clk);
    check("mid_rst_m_valid",  32'(bus.m_valid), 32'd0);
    check("mid_rst_s_ready",  32'(bus.s_ready), 32'd1);
    check("mid_rst_keep_err", 32'(keep_err),    32'd0);
    @(posedge clk); #1;
    mr_mode = 1;
    pkt_lanes = '{4'h7, 4'h6, 4'h5}; pkt_cnts = '{3};
    send_pkt(); wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
